// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo family: default word width and the
// occupancy type used by the read-side stream buffer.
package async_fifo_pkg;

    // Default word width of async_fifo and its read-side consumers.
    localparam int BITS_DEFAULT = 32;

    // Occupancy of the 2-entry read-side buffer: 0, 1 or 2 words.
    typedef logic [1:0] count_t;

    // Number of entries in the read-side output buffer.
    localparam count_t BUF_DEPTH = 2'd2;

endpackage

// File: rtl/fifo_read_stream_buf.sv
// Two-entry register buffer behind the FIFO read port. Words are written at
// the tail, presented from the head, and a flush drops everything held.
// Capture and pop in the same cycle keep the occupancy and advance both
// indices, so word order is preserved.
module fifo_read_stream_buf
    import async_fifo_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    input  logic            pop,
    input  logic            flush,
    output count_t          count,
    output logic [BITS-1:0] head_data
);

    logic [BITS-1:0] mem [2];
    logic            head;
    logic            tail;

    // Storage: write at the tail; contents are cleared only by reset so the
    // head entry reads as zero right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[tail] <= push_data;
        end
    end

    // Indices and occupancy: flush empties the buffer, otherwise each side
    // advances independently and wraps modulo 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count_t'(count + 2'd1);
                2'b01:   count <= count_t'(count - 2'd1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_read_stream.sv
// Read-side consumer for async_fifo. Pops words from the FIFO's registered
// read port and presents them as a registered valid/ready stream, hiding the
// one-cycle read latency with a 2-entry buffer so a continuously ready sink
// receives one word per cycle.
// Optional feature: define FIFO_READ_STREAM_COUNT_EN to add the p_beat_count
// output, a wrapping count of delivered beats that survives p_flush.
module fifo_read_stream
    import async_fifo_pkg::*;
#(
    parameter int BITS     = BITS_DEFAULT,
    parameter int CNT_BITS = 32
) (
    input  logic                read_clk,
    input  logic                read_rst_n,
    output logic                p_read_en,
    input  logic [BITS-1:0]     p_read_data,
    input  logic                p_read_empty,
    input  logic                p_flush,
    output logic                m_valid,
    output logic [BITS-1:0]     m_data,
    input  logic                m_ready
`ifdef FIFO_READ_STREAM_COUNT_EN
    ,
    output logic [CNT_BITS-1:0] p_beat_count
`endif
);

    typedef logic [CNT_BITS-1:0] beat_t;

    logic       inflight;
    logic       pop;
    logic       capture;
    count_t     count;
    logic [2:0] occupancy;

    // A word leaves whenever the head is valid and the sink accepts it.
    assign pop = m_valid && m_ready;

    // The word requested last cycle arrives now; a flush discards it.
    assign capture = inflight && !p_flush;

    // Words that will be held or in flight after this cycle's pop. A pop
    // implies count >= 1, so this never underflows.
    assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);

    // Request a word only when it is guaranteed a buffer slot on arrival.
    // Gating with the reset keeps the request low while the block is held
    // in reset, even if the FIFO reports data.
    assign p_read_en = read_rst_n && !p_read_empty && !p_flush
                       && (occupancy < 3'(BUF_DEPTH));

    // Track the pop issued last cycle; its data is valid this cycle.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= p_read_en;
        end
    end

    fifo_read_stream_buf #(
        .BITS (BITS)
    ) u_buf (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .push      (capture),
        .push_data (p_read_data),
        .pop       (pop),
        .flush     (p_flush),
        .count     (count),
        .head_data (m_data)
    );

    assign m_valid = (count != '0);

`ifdef FIFO_READ_STREAM_COUNT_EN
    // Count every delivered beat, including one accepted during a flush.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            p_beat_count <= '0;
        end else if (pop) begin
            p_beat_count <= beat_t'(p_beat_count + beat_t'(1));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream. The FIFO is modelled as a queue of pending
// words with a one-cycle registered read; the expected output is the ordered
// list of words popped from that queue, minus any dropped by a flush.
module tb_fifo_read_stream;

    localparam int BITS = 32;
`ifdef FIFO_READ_STREAM_COUNT_EN
    localparam int CNT_BITS = 4;
`else
    localparam int CNT_BITS = 32;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                p_read_en;
    logic [BITS-1:0]     p_read_data;
    logic                p_read_empty;
    logic                p_flush;
    logic                m_valid;
    logic [BITS-1:0]     m_data;
    logic                m_ready;
`ifdef FIFO_READ_STREAM_COUNT_EN
    logic [CNT_BITS-1:0] beat_count;
`endif

    fifo_read_stream #(
        .BITS     (BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .read_clk     (clk),
        .read_rst_n   (rst_n),
        .p_read_en    (p_read_en),
        .p_read_data  (p_read_data),
        .p_read_empty (p_read_empty),
        .p_flush      (p_flush),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready)
`ifdef FIFO_READ_STREAM_COUNT_EN
        ,
        .p_beat_count (beat_count)
`endif
    );

    always #5 clk = ~clk;

    int              errors = 0;
    int              checks = 0;
    int              delivered = 0;
    int              pushed = 0;
    int              discarded = 0;
    logic [BITS-1:0] src_q[$];
    logic [BITS-1:0] exp_q[$];
    bit              force_empty = 1'b0;
    bit              s_en;
    bit              s_valid;
    logic [BITS-1:0] s_data;
    bit              prev_stall = 1'b0;
    logic [BITS-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(rnd ? BITS'($urandom) : BITS'(i + 1));
            pushed++;
        end
    endtask

    // One clock cycle: sample at the falling edge, update the model, then
    // present the FIFO's registered read data just after the rising edge.
    task automatic tick();
        logic [BITS-1:0]     w;
        logic [CNT_BITS-1:0] exp_cnt;
        w = '0;
        p_read_empty = force_empty || (src_q.size() == 0);
        @(negedge clk);
        s_en    = p_read_en;
        s_valid = m_valid;
        s_data  = m_data;
        if (s_en) check("read_en_while_empty", p_read_empty, 0);
        if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
        end
        exp_cnt = delivered[CNT_BITS-1:0];
`ifdef FIFO_READ_STREAM_COUNT_EN
        check("beat_count", beat_count, exp_cnt);
`endif
        if (m_valid && m_ready) begin
            check("word_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("data", m_data, exp_q.pop_front());
            delivered++;
        end
        prev_stall = m_valid && !m_ready && !p_flush;
        prev_data  = m_data;
        if (p_flush) begin
            discarded += exp_q.size();
            exp_q.delete();
        end
        if (s_en && src_q.size() > 0) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
        end
        check("occupancy_le_2", exp_q.size() <= 2, 1);
        @(posedge clk);
        #1;
        p_read_data = s_en ? w : BITS'($urandom);
    endtask

    task automatic drain(input int limit);
        force_empty = 1'b0;
        m_ready     = 1'b1;
        for (int i = 0; i < limit && (src_q.size() > 0 || exp_q.size() > 0); i++) tick();
        check("drained_src", src_q.size(), 0);
        check("drained_out", exp_q.size(), 0);
        check("conservation", delivered + discarded, pushed);
    endtask

    initial begin
        int t;
        rst_n       = 1'b0;
        m_ready     = 1'b1;
        p_flush     = 1'b0;
        p_read_data = '0;

        // Reset with data available in the FIFO
        load(16, 1'b0);
        tick();
        check("rst_read_en", s_en, 0);
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        tick();
        check("rst_read_en_2", s_en, 0);
        rst_n = 1'b1;

        // First-word latency, then sustained streaming
        tick();
        check("first_read_en", s_en, 1);
        tick();
        check("latency_n1_valid", s_valid, 0);
        tick();
        check("latency_n2_valid", s_valid, 1);
        check("first_word", s_data, 1);
        t = 0;
        while (delivered < 16 && t < 40) begin
            tick();
            t++;
        end
        check("smoke_no_gaps", t, 15);
        check("smoke_count", delivered, 16);
        drain(10);

        // Backpressure for 10 cycles mid-stream
        load(20, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("bp_read_en_stopped", s_en, 0);
        check("bp_valid_held", s_valid, 1);
        check("bp_buffered", exp_q.size(), 2);
        drain(100);

        // FIFO empty flag toggling every cycle, random sink readiness
        load(12, 1'b1);
        for (int i = 0; i < 200 && (src_q.size() > 0 || exp_q.size() > 0); i++) begin
            force_empty = ~force_empty;
            m_ready     = 1'($urandom_range(0, 1));
            tick();
        end
        drain(20);

        // Flush with a full buffer, popping in the flush cycle
        load(10, 1'b1);
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_flush_occ", exp_q.size(), 2);
        p_flush = 1'b1;
        m_ready = 1'b1;
        tick();
        check("flush_read_en", s_en, 0);
        p_flush = 1'b0;
        tick();
        check("post_flush_valid", s_valid, 0);
        drain(50);

        // Flush during full-rate streaming with a word in flight
        load(10, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        p_flush = 1'b1;
        tick();
        check("flush2_read_en", s_en, 0);
        p_flush = 1'b0;
        drain(50);

        // Random readiness with occasional flushes
        load(30, 1'b1);
        for (int i = 0; i < 300 && (src_q.size() > 0 || exp_q.size() > 0); i++) begin
            m_ready = 1'($urandom_range(0, 1));
            p_flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        p_flush = 1'b0;
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
